ctrl_pipe_reg: RTL and testbench
================================

// Module: ctrl_pipe_reg
// PURPOSE
//   Parametrised control-signal pipeline register for the processor datapath.
//   Carries a WIDTH-bit control bundle (mem_write, mem_read, mem_to_reg, reg_write, ...)
//   and a valid bit through DEPTH register stages, with stall, flush and bubble insertion.
//   Drops in between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) and guarantees that
//   invalid slots never carry asserted control bits.
// PARAMETERS
//   WIDTH    5       control bundle width in bits (>=1)
//   DEPTH    1       number of register stages, i.e. latency in cycles (>=1)
//   RST_VAL  0       WIDTH-bit value held by every empty, flushed or bubbled slot
//   CNT_W    16      width of the stall statistics counter
// PORTS
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous active-high reset
//   in_valid    in   1            input slot holds a real instruction
//   in_data     in   WIDTH        control bundle from the previous stage
//   stall       in   1            hold all stages; input not accepted
//   flush       in   1            kill every in-flight slot (branch taken, exception)
//   bubble      in   1            insert an empty slot at stage 0 (load-use hazard)
//   out_valid   out  1            valid bit of last stage
//   out_data    out  WIDTH        control bundle of last stage
//   stage_valid out  DEPTH        valid bit of each stage, bit 0 = stage nearest input
//   occ         out  $clog2(DEPTH+1)  number of valid stages (popcount of stage_valid)
//   stall_cnt   out  CNT_W        cycles spent stalled since reset, saturating
// BEHAVIOUR
//   - Stages s[0..DEPTH-1] each hold {v, d}. out_valid/out_data = s[DEPTH-1], registered.
//   - Update priority, evaluated every rising edge: rst > flush > stall > bubble > advance.
//   - rst: all v=0, all d=RST_VAL, stall_cnt=0. Result: out_valid=0, out_data=RST_VAL,
//     stage_valid=0, occ=0.
//   - flush: all v=0, all d=RST_VAL next cycle. Overrides stall and bubble. stall_cnt unchanged.
//   - stall (no flush): every stage holds its value and in_* is ignored.
//     stall_cnt increments by 1 and saturates at 2^CNT_W-1 with no wrap.
//   - bubble (no flush, no stall): s[0] <= {0, RST_VAL}; s[i] <= s[i-1] for i>=1.
//     in_* is dropped; the upstream stage must hold it.
//   - advance: s[0] <= {in_valid, in_valid ? in_data : RST_VAL}; s[i] <= s[i-1].
//     Squash rule: any slot with v=0 always has d=RST_VAL, so no stray write enables pass.
//   - Latency: an accepted input appears on out_* exactly DEPTH un-stalled, un-bubbled
//     edges later. Stall cycles add 1 each. Bubble cycles do not delay slots already in flight.
//   - DEPTH=1: a single register with squash, stall, flush and bubble.
//   - occ and stage_valid are combinational from the registered v bits.
//   - stall_cnt counts only cycles where stall=1 and flush=0 and rst=0.
//   - rst asserted mid-stream discards all slots on that edge. The first valid output
//     after reset release needs DEPTH advance edges.
// TESTING
//   1. DEPTH=3, WIDTH=5: push 5'h1F, 5'h0A, 5'h15 with in_valid=1 on consecutive cycles
//      -> out_data is 1F, 0A, 15 on cycles 3, 4, 5 and out_valid=1; occ reaches 3.
//   2. in_valid=0 with in_data=5'h1F -> slot emerges with out_valid=0, out_data=RST_VAL (0).
//   3. Pipe full (occ=3), stall=1 for 4 cycles -> outputs frozen, stall_cnt=4.
//      Then stall=0 -> draining resumes in order.
//   4. Stages hold A,B,C; bubble=1 for one cycle -> stage_valid=3'b110 next cycle.
//      C exits on schedule; in_data offered during the bubble is not captured.
//   5. stall=1 and flush=1 together while occ=3 -> next cycle occ=0, out_data=0,
//      stall_cnt unchanged.
//   6. CNT_W=4, stall held 20 cycles -> stall_cnt saturates at 15.
//      rst=1 mid-stream -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ctrl_pipe_reg.sv
// Control-bundle pipeline register: DEPTH stages of {valid, data} with stall, flush and bubble.
// Slots with valid=0 always carry RST_VAL, so no asserted control bits leak downstream.
module ctrl_pipe_reg #(
  parameter int unsigned           WIDTH   = 5,
  parameter int unsigned           DEPTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter int unsigned           CNT_W   = 16,
  localparam int unsigned          OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             bubble,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] stage_valid,
  output logic [OCC_W-1:0] occ,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];

  logic             head_v;
  logic [WIDTH-1:0] head_d;

  // A bubble enters as an empty slot; an invalid input is squashed to RST_VAL.
  always_comb begin
    head_v = in_valid & ~bubble;
    head_d = head_v ? in_data : RST_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RST_VAL;
    end else if (!stall) begin
      v_q[0] <= head_v;
      d_q[0] <= head_d;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(v_q[i]);
  end

  assign stage_valid = v_q;
  assign out_valid   = v_q[DEPTH-1];
  assign out_data    = d_q[DEPTH-1];

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed bench for ctrl_pipe_reg at DEPTH=3, WIDTH=5, CNT_W=4.
module tb_ctrl_pipe_reg;
  localparam int WIDTH = 5;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, stall, flush, bubble;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] stage_valid;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  ctrl_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .bubble(bubble),
    .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0; bubble = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stage_valid", stage_valid, 0);
    check("rst_occ", occ, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // basic latency and squash of an invalid slot
    push(1, 5'h1F);
    check("t1_sv1", stage_valid, 3'b001);
    check("t1_occ1", occ, 1);
    push(1, 5'h0A);
    check("t1_out_empty", out_valid, 0);
    push(1, 5'h15);
    check("t1_occ3", occ, 3);
    check("t1_v0", out_valid, 1);
    check("t1_d0", out_data, 5'h1F);
    push(0, 5'h1F);
    check("t1_d1", out_data, 5'h0A);
    check("t1_sv_drain", stage_valid, 3'b110);
    push(0, 5'h1F);
    check("t1_v2", out_valid, 1);
    check("t1_d2", out_data, 5'h15);
    push(0, 5'h1F);
    check("t2_v", out_valid, 0);
    check("t2_d_squash", out_data, 0);

    // stall on a full pipe
    push(1, 5'h01); push(1, 5'h02); push(1, 5'h03);
    check("t3_full", occ, 3);
    stall = 1'b1; in_valid = 1'b1; in_data = 5'h1E;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_frozen_d", out_data, 5'h01);
      check("t3_frozen_occ", occ, 3);
    end
    check("t3_stall_cnt", stall_cnt, 4);
    stall = 1'b0;
    push(0, 5'h00);
    check("t3_drain1", out_data, 5'h02);
    push(0, 5'h00);
    check("t3_drain2", out_data, 5'h03);
    check("t3_drain2_v", out_valid, 1);
    push(0, 5'h00);
    check("t3_empty", out_valid, 0);
    check("t3_cnt_hold", stall_cnt, 4);

    // bubble insertion
    push(1, 5'h04); push(1, 5'h05); push(1, 5'h06);
    bubble = 1'b1;
    push(1, 5'h1D);
    bubble = 1'b0;
    check("t4_sv", stage_valid, 3'b110);
    check("t4_d_b", out_data, 5'h05);
    push(0, 5'h00);
    check("t4_c_v", out_valid, 1);
    check("t4_c_d", out_data, 5'h06);
    push(0, 5'h00);
    check("t4_bubble_v", out_valid, 0);
    check("t4_bubble_d", out_data, 0);
    check("t4_occ", occ, 0);

    // stall beats bubble
    push(1, 5'h10); push(1, 5'h11); push(1, 5'h12);
    stall = 1'b1; bubble = 1'b1;
    push(1, 5'h13);
    check("stall_over_bubble_sv", stage_valid, 3'b111);
    check("stall_over_bubble_d", out_data, 5'h10);
    check("stall_over_bubble_cnt", stall_cnt, 5);

    // flush beats stall, counter unchanged
    bubble = 1'b0; flush = 1'b1;
    push(1, 5'h14);
    flush = 1'b0; stall = 1'b0;
    check("t5_occ", occ, 0);
    check("t5_d", out_data, 0);
    check("t5_v", out_valid, 0);
    check("t5_cnt", stall_cnt, 5);

    // counter saturation
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("t6_sat", stall_cnt, 15);
    stall = 1'b0;

    // reset mid-stream
    push(1, 5'h0B); push(1, 5'h0C);
    check("t6_pre_rst_occ", occ, 2);
    rst = 1'b1;
    push(1, 5'h0D);
    rst = 1'b0;
    check("t6_rst_occ", occ, 0);
    check("t6_rst_sv", stage_valid, 0);
    check("t6_rst_v", out_valid, 0);
    check("t6_rst_d", out_data, 0);
    check("t6_rst_cnt", stall_cnt, 0);
    push(1, 5'h0E); push(0, 5'h00);
    check("post_rst_lat2", out_valid, 0);
    push(0, 5'h00);
    check("post_rst_v", out_valid, 1);
    check("post_rst_d", out_data, 5'h0E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
